instr_decode_q: RTL
===================

INSTR_DECODE_Q -- requirements
Module: instr_decode_q

Interface
REQ-001 The block SHALL have parameter op_size, default 4, meaning opcode field width.
REQ-002 The block SHALL have parameter param_a_size, default 4, meaning parameter-A field width.
REQ-003 The block SHALL have parameter param_b_size, default 4, meaning parameter-B field width.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning queue entries; it SHALL be a power of 2 and at least 2.
REQ-005 The block SHALL have parameter OP_LEGAL_MASK, default 16'h00FF, meaning 2^op_size bits where bit k set means opcode k is legal.
REQ-006 The block SHALL define CODE_W = op_size+param_a_size+param_b_size and CNT_W = $clog2(DEPTH+1).
REQ-007 The block SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- code  in  CODE_W  instruction word.
- code_valid  in  1  code is valid this cycle.
- code_ready  out  1  queue can accept code.
- flush  in  1  synchronous queue clear.
- op  out  op_size  head opcode.
- act_type  out  param_a_size  head parameter A.
- dense_type  out  param_b_size  head parameter B.
- cost_type  out  param_a_size+param_b_size  head combined A:B.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer takes head.
- illegal  out  1  head opcode is not legal.
- err_sticky  out  1  an illegal opcode has been popped since reset.
- illegal_cnt  out  8  saturating count of illegal pops.
- count  out  CNT_W  current occupancy.

Function
REQ-008 The queue SHALL be a circular FIFO of DEPTH entries of CODE_W bits, with read/write pointers that wrap modulo DEPTH.
REQ-009 A push SHALL occur when code_valid && code_ready at a rising edge.
REQ-010 A pop SHALL occur when out_valid && out_ready at a rising edge.
REQ-011 code_ready SHALL equal (count != DEPTH) while rst_n is high and SHALL be 0 while rst_n is low; it SHALL NOT depend on out_ready.
REQ-012 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-013 Simultaneous push and pop at count==0 SHALL NOT be possible, since out_valid=0; only the push SHALL occur.
REQ-014 The queue SHALL be first-word fall-through: a word pushed at edge N SHALL appear on the outputs, with out_valid=1, in the cycle after edge N when the queue was empty.
REQ-015 out_valid SHALL equal (count != 0).
REQ-016 Field slicing of the head word h SHALL be:
- op = h[CODE_W-1 -: op_size]
- act_type = h[param_a_size+param_b_size-1 -: param_a_size]
- dense_type = h[param_b_size-1 -: param_b_size]
- cost_type = h[param_a_size+param_b_size-1 : 0]
REQ-017 op, act_type, dense_type and cost_type SHALL be 0 when out_valid=0.
REQ-018 illegal SHALL equal out_valid && !OP_LEGAL_MASK[op], combinationally from the head.
REQ-019 Illegal entries SHALL be popped like legal ones and SHALL NOT stall the queue.
REQ-020 Each pop with illegal=1 SHALL set err_sticky and increment illegal_cnt, saturating at 255.
REQ-021 flush=1 at an edge SHALL zero both pointers and count, and SHALL take priority over a same-cycle push and pop; the pushed word SHALL be dropped.
REQ-022 flush SHALL NOT clear err_sticky or illegal_cnt, and a pop suppressed by flush SHALL NOT count as an illegal pop.
REQ-023 count SHALL change by at most 1 per cycle, except on flush.

Reset
REQ-024 rst_n low SHALL immediately, independent of clk, clear pointers, count, err_sticky and illegal_cnt, and force code_ready=0 and out_valid=0.
REQ-025 While rst_n is low, all field outputs and illegal SHALL read 0.
REQ-026 Queue storage contents SHALL NOT require reset.
REQ-027 A push request in the same cycle as reset release SHALL be ignored; code_ready SHALL rise in that cycle and a push SHALL be accepted from the next edge.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries.

Verification (defaults)
REQ-029 Push 12'h3A5 into an empty queue with out_ready=0 -> next cycle: out_valid=1, op=4'h3, act_type=4'hA, dense_type=4'h5, cost_type=8'hA5, count=1, illegal=0.
REQ-030 Drive 5 consecutive pushes with out_ready=0 -> count=4 and code_ready=0 after the 4th; the 5th word is held; after one pop, the 5th word is accepted and pop order matches push order.
REQ-031 At count=4, hold code_valid=1 and out_ready=1 -> cycle 1: pop only, count=3; cycle 2: push and pop together, count stays 3.
REQ-032 Push 12'h912 then pop -> while at head, illegal=1; after the pop, err_sticky=1 and illegal_cnt=1; a following legal 12'h012 pops normally with illegal=0.
REQ-033 At count=3, assert flush with code_valid=1 and out_ready=1 -> next cycle: count=0, out_valid=0, fields=0; the pushed word is lost and err_sticky is unchanged.
REQ-034 Assert rst_n low between clock edges with count=2 and err_sticky=1 -> immediately: count=0, out_valid=0, code_ready=0, err_sticky=0, illegal_cnt=0.

Source files
------------

// File: rtl/instr_decode_q.sv
// Instruction decode queue: a first-word fall-through FIFO of packed
// instruction words. The head word is sliced into opcode and parameter
// fields, and the opcode is flagged as illegal against a legality mask.
// Illegal pops are recorded in a sticky flag and a saturating counter.
module instr_decode_q #(
  parameter int op_size      = 4,
  parameter int param_a_size = 4,
  parameter int param_b_size = 4,
  parameter int DEPTH        = 4,
  parameter logic [(1<<op_size)-1:0] OP_LEGAL_MASK = 16'h00FF,
  localparam int CODE_W = op_size + param_a_size + param_b_size,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CODE_W-1:0]                  code,
  input  logic                               code_valid,
  output logic                               code_ready,
  input  logic                               flush,
  output logic [op_size-1:0]                 op,
  output logic [param_a_size-1:0]            act_type,
  output logic [param_b_size-1:0]            dense_type,
  output logic [param_a_size+param_b_size-1:0] cost_type,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               illegal,
  output logic                               err_sticky,
  output logic [7:0]                         illegal_cnt,
  output logic [CNT_W-1:0]                   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int AB_W  = param_a_size + param_b_size;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_sticky_q, err_sticky_d;
  logic [7:0]        illegal_cnt_q, illegal_cnt_d;
  logic              armed_q;
  logic [CODE_W-1:0] head;
  logic [op_size-1:0] head_op;
  logic              push, pop;

  // armed_q stays low for the first edge after reset release so a request
  // presented in the release cycle is ignored even though code_ready is high.
  assign code_ready = rst_n && (count_q != FULL);
  assign out_valid  = (count_q != '0);
  assign push       = code_valid && code_ready && armed_q;
  assign pop        = out_valid && out_ready;

  assign head    = mem_q[rd_ptr_q];
  assign head_op = head[CODE_W-1 -: op_size];

  assign op         = out_valid ? head_op : '0;
  assign act_type   = out_valid ? head[AB_W-1 -: param_a_size] : '0;
  assign dense_type = out_valid ? head[param_b_size-1 -: param_b_size] : '0;
  assign cost_type  = out_valid ? head[AB_W-1:0] : '0;
  assign illegal    = out_valid && !OP_LEGAL_MASK[head_op];

  assign count       = count_q;
  assign err_sticky  = err_sticky_q;
  assign illegal_cnt = illegal_cnt_q;

  // Next-state for pointers, occupancy and error tracking; flush wins over push and pop.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    err_sticky_d  = err_sticky_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (pop && illegal) begin
        err_sticky_d = 1'b1;
        if (illegal_cnt_q != 8'hFF) begin
          illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
      end
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_sticky_q  <= 1'b0;
      illegal_cnt_q <= 8'd0;
      armed_q       <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_sticky_q  <= err_sticky_d;
      illegal_cnt_q <= illegal_cnt_d;
      armed_q       <= 1'b1;
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= code;
    end
  end

endmodule
